// File: rtl/instr_prefetch_unit.sv
// ============================================================================
// Module   : instr_prefetch_unit
// Purpose  : Sequential instruction fetch with a DEPTH-entry word/PC FIFO and
//            redirect-driven flush. Optional macro: PREFETCH_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_prefetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
`ifdef PREFETCH_STATS_EN
    output logic [15:0] stat_fetch_o,
    output logic [15:0] stat_flush_o,
    output logic [15:0] stat_drop_o,
`endif
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   hold_addr_q, hold_addr_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   head_data_q, head_data_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   mem_data_q [DEPTH];
    logic [31:0]   mem_pc_q   [DEPTH];

    logic          push;
    logic          pop;
    logic          drop;
    logic [1:0]    unused_pc_lsbs;

    assign unused_pc_lsbs = redirect_pc_i[1:0];

    // Redirect suppresses both FIFO ports in its cycle.
    assign push = (state_q == S_REQ) && imem_ack_i && !redirect_i;
    assign pop  = (count_q != '0) && instr_ready_i && !redirect_i;
    assign drop = imem_ack_i && ((state_q == S_DISCARD) ||
                                 ((state_q == S_REQ) && redirect_i));

    assign imem_req_o    = (state_q != S_IDLE);
    assign imem_addr_o   = (state_q == S_DISCARD) ? hold_addr_q : fetch_pc_q;
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = head_data_q;
    assign instr_pc_o    = head_pc_q;

    always_comb begin
        count_d     = count_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        head_data_d = head_data_q;
        head_pc_d   = head_pc_q;
        if (redirect_i) begin
            count_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
            // The head register is loaded from the incoming word only when that
            // word becomes the head; otherwise from the stored entry after pop.
            if (push && ((count_q == '0) || ((count_q == ONE) && pop))) begin
                head_data_d = imem_data_i;
                head_pc_d   = fetch_pc_q;
            end else if (pop && (count_q > ONE)) begin
                head_data_d = mem_data_q[rptr_d];
                head_pc_d   = mem_pc_q[rptr_d];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        hold_addr_d = hold_addr_q;
        case (state_q)
            S_IDLE: begin
                if (redirect_i || (count_q != FULL)) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_ack_i) begin
                    if (!redirect_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = (count_d != FULL) ? S_REQ : S_IDLE;
                    end
                end else if (redirect_i) begin
                    state_d     = S_DISCARD;
                    hold_addr_d = fetch_pc_q;
                end
            end
            S_DISCARD: begin
                if (imem_ack_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
        // In DISCARD fetch_pc_q already holds the pending target.
        if (redirect_i) fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            hold_addr_q <= RESET_PC;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            head_data_q <= '0;
            head_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            hold_addr_q <= hold_addr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_pc_q   <= head_pc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data_q[wptr_q] <= imem_data_i;
            mem_pc_q[wptr_q]   <= fetch_pc_q;
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_fetch_q;
    logic [15:0] stat_flush_q;
    logic [15:0] stat_drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_fetch_q <= '0;
            stat_flush_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            if (push && (stat_fetch_q != 16'hFFFF))       stat_fetch_q <= stat_fetch_q + 16'd1;
            if (redirect_i && (stat_flush_q != 16'hFFFF)) stat_flush_q <= stat_flush_q + 16'd1;
            if (drop && (stat_drop_q != 16'hFFFF))        stat_drop_q  <= stat_drop_q + 16'd1;
        end
    end

    assign stat_fetch_o = stat_fetch_q;
    assign stat_flush_o = stat_flush_q;
    assign stat_drop_o  = stat_drop_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_unit.sv
// ============================================================================
// Module   : tb_instr_prefetch_unit
// Purpose  : Directed bench with a variable-latency memory model and a
//            scoreboard of expected delivered PCs for instr_prefetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_prefetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_fetch_o;
    logic [15:0] stat_flush_o;
    logic [15:0] stat_drop_o;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          lat      = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc   = RESET_PC;
    logic [31:0] disc_addr = '0;
    bit          disc      = 0;
    bit          prev_pend = 0;
    logic [31:0] prev_addr = '0;

    instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
`ifdef PREFETCH_STATS_EN
        .stat_fetch_o  (stat_fetch_o),
        .stat_flush_o  (stat_flush_o),
        .stat_drop_o   (stat_drop_o),
`endif
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic reset_seq();
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        tick(2);
        rst_i = 1'b0;
    endtask

    task automatic wait_req_addr(input logic [31:0] a, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (imem_req_o && imem_addr_o === a) found = 1;
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    // Memory: acks each request after 'lat' wait cycles, data is a hash of the address.
    initial begin
        int wcnt;
        wcnt        = 0;
        imem_ack_i  = 1'b0;
        imem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #1;
            if (imem_req_o === 1'b1) begin
                if (wcnt >= lat) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = mem_word(imem_addr_o);
                    wcnt        = 0;
                end else begin
                    imem_ack_i = 1'b0;
                    wcnt++;
                end
            end else begin
                imem_ack_i = 1'b0;
                wcnt       = 0;
            end
        end
    end

    // Scoreboard: kept acks push the expected PC, handshakes pop and compare.
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (rst_i) begin
            exp_q.delete();
            disc      = 0;
            exp_pc    = RESET_PC;
            prev_pend = 0;
        end else begin
            check("valid_vs_model", {31'd0, instr_valid_o}, {31'd0, exp_q.size() != 0});
            if (prev_pend) begin
                check("bus_req_hold", {31'd0, imem_req_o}, 32'd1);
                check("bus_addr_hold", imem_addr_o, prev_addr);
            end
            if (imem_req_o && !disc)
                check("req_only_with_space", {31'd0, exp_q.size() < DEPTH}, 32'd1);
            if (instr_valid_o && instr_ready_i && !redirect_i && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc_o, e);
                check("instr_data", instr_o, mem_word(e));
            end
            if (imem_req_o && imem_ack_i) begin
                check("ack_addr", imem_addr_o, disc ? disc_addr : exp_pc);
                if (!disc && !redirect_i) begin
                    exp_q.push_back(exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                disc = 0;
            end else if (imem_req_o && redirect_i && !disc) begin
                disc      = 1;
                disc_addr = exp_pc;
            end
            if (redirect_i) begin
                exp_q.delete();
                exp_pc = {redirect_pc_i[31:2], 2'b00};
            end
            checks++;
            assert (exp_q.size() <= DEPTH) else begin
                failures++;
                $error("FAIL fifo_overflow observed=%0d expected<=%0d", exp_q.size(), DEPTH);
            end
            prev_pend = imem_req_o && !imem_ack_i;
            prev_addr = imem_addr_o;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef PREFETCH_STATS_EN
        logic [15:0] drop0, flush0;
`endif
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;

        // Reset state and zero-wait stream
        tick(2);
        @(negedge clk_i);
        check("rst_req", {31'd0, imem_req_o}, 32'd0);
        check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", instr_pc_o, 32'd0);
        tick(1);
        rst_i = 1'b0;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        check("idle_first_cycle", {31'd0, imem_req_o}, 32'd0);
        tick(1);
        @(negedge clk_i);
        check("first_req", {31'd0, imem_req_o}, 32'd1);
        check("first_addr", imem_addr_o, RESET_PC);
        tick(1);
        @(negedge clk_i);
        check("stream_addr1", imem_addr_o, 32'd4);
        check("stream_head0", instr_pc_o, 32'd0);
        tick(2);
        @(negedge clk_i);
        check("stream_addr3", imem_addr_o, 32'd12);
        check("stream_head2", instr_pc_o, 32'd8);
        tick(6);

        // Backpressure: four words buffered, then delivered gap-free
        instr_ready_i = 1'b0;
        reset_seq();
        tick(10);
        @(negedge clk_i);
        check("bp_req_low", {31'd0, imem_req_o}, 32'd0);
        check("bp_valid", {31'd0, instr_valid_o}, 32'd1);
        tick(1);
        instr_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_drain_valid", {31'd0, instr_valid_o}, 32'd1);
            check("bp_drain_pc", instr_pc_o, 32'(4 * i));
            tick(1);
        end
        tick(4);

        // Redirect while a slow fetch is outstanding
        lat = 3;
        reset_seq();
        wait_req_addr(32'h10, "wait_req_0x10");
        tick(1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        tick(1);
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("disc_req", {31'd0, imem_req_o}, 32'd1);
        check("disc_addr_held", imem_addr_o, 32'h10);
        check("disc_valid", {31'd0, instr_valid_o}, 32'd0);
        wait_req_addr(32'h100, "req_after_discard");
        for (int i = 0; i < 20 && !instr_valid_o; i++) @(negedge clk_i);
        check("disc_first_pc", instr_pc_o, 32'h100);
        check("disc_first_data", instr_o, mem_word(32'h100));
        tick(3);

        // Redirect coincident with ack and pop, two entries buffered
        lat = 0;
        instr_ready_i = 1'b0;
        reset_seq();
        tick(3);
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        @(negedge clk_i);
        check("coinc_pre_valid", {31'd0, instr_valid_o}, 32'd1);
        check("coinc_pre_req", {31'd0, imem_req_o}, 32'd1);
`ifdef PREFETCH_STATS_EN
        drop0  = stat_drop_o;
        flush0 = stat_flush_o;
`endif
        tick(1);
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("coinc_valid", {31'd0, instr_valid_o}, 32'd0);
        check("coinc_addr", imem_addr_o, 32'h200);
`ifdef PREFETCH_STATS_EN
        check("coinc_stat_drop", {16'd0, stat_drop_o}, {16'd0, drop0 + 16'd1});
        check("coinc_stat_flush", {16'd0, stat_flush_o}, {16'd0, flush0 + 16'd1});
`endif
        tick(4);

        // Reset while in DISCARD
        lat = 3;
        reset_seq();
        tick(2);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_0300;
        tick(1);
        redirect_i = 1'b0;
        rst_i      = 1'b1;
        @(negedge clk_i);
        check("rd_pre_addr", imem_addr_o, RESET_PC);
        tick(1);
        @(negedge clk_i);
        check("rd_req", {31'd0, imem_req_o}, 32'd0);
        check("rd_valid", {31'd0, instr_valid_o}, 32'd0);
        tick(1);
        rst_i = 1'b0;
        tick(1);
        @(negedge clk_i);
        check("rd_restart_req", {31'd0, imem_req_o}, 32'd1);
        check("rd_restart_addr", imem_addr_o, RESET_PC);
        tick(4);

        // Wrap-around of the fetch address
        lat = 0;
        reset_seq();
        tick(3);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick(1);
        redirect_i = 1'b0;
        @(negedge clk_i);
        check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
        check("wrap_valid0", {31'd0, instr_valid_o}, 32'd0);
        tick(1);
        @(negedge clk_i);
        check("wrap_addr1", imem_addr_o, 32'h0000_0000);
        check("wrap_pc0", instr_pc_o, 32'hFFFF_FFFC);
        tick(1);
        @(negedge clk_i);
        check("wrap_pc1", instr_pc_o, 32'h0000_0000);
        tick(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
